// File: rtl/shot_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : shot_sequencer
// Brief   : Player-side round controller that aims, fires and scores shots
//           resolved by trajectory_calc.
// Rev     : 1.0  initial release
// ============================================================================
module shot_sequencer #(
  parameter int         SHOTS     = 8,
  parameter int         TIMEOUT   = 63,
  parameter logic [9:0] LFSR_SEED = 10'h2A5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_fire,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_run,
  input  logic       btn_dir,
  input  logic       result_valid,
  input  logic       hit,
  input  logic [4:0] positionx,
  output logic [4:0] xpos,
  output logic [4:0] rise_out,
  output logic [4:0] run_out,
  output logic       direction_out,
  output logic       shoot,
  output logic [4:0] target_x,
  output logic [4:0] target_y,
  output logic [3:0] score,
  output logic [3:0] shots_left,
  output logic [4:0] last_impact_x,
  output logic       busy,
  output logic       game_over,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_AIM   = 3'd1,
    S_FIRE  = 3'd2,
    S_WAIT  = 3'd3,
    S_SCORE = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  localparam logic [3:0] c_shots   = 4'(SHOTS);
  localparam logic [7:0] c_timeout = 8'(TIMEOUT);

  state_t     r_state;
  logic [9:0] r_lfsr;
  logic [7:0] r_btn_prev;
  logic [7:0] r_wait_cnt;
  logic       r_hit;
  logic       r_resolved;
  logic [4:0] r_impact;

  logic [7:0] w_btn;
  logic [7:0] w_edge;
  logic       w_start_e, w_fire_e, w_left_e, w_right_e;
  logic       w_up_e, w_down_e, w_run_e, w_dir_e;
  logic       w_lfsr_fb;
  logic [4:0] w_new_tx;
  logic [4:0] w_new_ty;

  assign w_btn  = {btn_start, btn_fire, btn_left, btn_right,
                   btn_up, btn_down, btn_run, btn_dir};
  assign w_edge = w_btn & ~r_btn_prev;
  assign {w_start_e, w_fire_e, w_left_e, w_right_e,
          w_up_e, w_down_e, w_run_e, w_dir_e} = w_edge;

  assign w_lfsr_fb = r_lfsr[9] ^ r_lfsr[6];
  assign w_new_tx  = r_lfsr[4:0];
  // A zero row would put the target on the ground line, so it is bumped to 1.
  assign w_new_ty  = (r_lfsr[9:5] == 5'd0) ? 5'd1 : r_lfsr[9:5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_lfsr        <= LFSR_SEED;
      r_btn_prev    <= 8'd0;
      r_wait_cnt    <= 8'd0;
      r_hit         <= 1'b0;
      r_resolved    <= 1'b0;
      r_impact      <= 5'd0;
      xpos          <= 5'd16;
      rise_out      <= 5'd0;
      run_out       <= 5'd1;
      direction_out <= 1'b0;
      shoot         <= 1'b0;
      target_x      <= 5'd0;
      target_y      <= 5'd0;
      score         <= 4'd0;
      shots_left    <= 4'd0;
      last_impact_x <= 5'd0;
      busy          <= 1'b0;
      game_over     <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      r_lfsr     <= {r_lfsr[8:0], w_lfsr_fb};
      r_btn_prev <= w_btn;
      shoot      <= 1'b0;

      case (r_state)
        S_IDLE, S_OVER: begin
          if (w_start_e) begin
            score       <= 4'd0;
            shots_left  <= c_shots;
            timeout_err <= 1'b0;
            target_x    <= w_new_tx;
            target_y    <= w_new_ty;
            game_over   <= 1'b0;
            r_state     <= S_AIM;
          end
        end

        S_AIM: begin
          if (w_fire_e) begin
            shoot   <= 1'b1;
            busy    <= 1'b1;
            r_state <= S_FIRE;
          end else begin
            if (w_left_e && !w_right_e && xpos != 5'd0)
              xpos <= xpos - 5'd1;
            else if (w_right_e && !w_left_e && xpos != 5'd31)
              xpos <= xpos + 5'd1;

            if (w_up_e && !w_down_e && rise_out != 5'd31)
              rise_out <= rise_out + 5'd1;
            else if (w_down_e && !w_up_e && rise_out != 5'd0)
              rise_out <= rise_out - 5'd1;

            // Run skips zero so the slope is always defined.
            if (w_run_e)
              run_out <= (run_out == 5'd31) ? 5'd1 : run_out + 5'd1;

            if (w_dir_e)
              direction_out <= ~direction_out;
          end
        end

        S_FIRE: begin
          r_wait_cnt <= 8'd0;
          r_state    <= S_WAIT;
        end

        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 8'd1;
          if (result_valid) begin
            r_hit      <= hit;
            r_resolved <= 1'b1;
            r_impact   <= positionx;
            r_state    <= S_SCORE;
          end else if (r_wait_cnt == c_timeout) begin
            r_hit       <= 1'b0;
            r_resolved  <= 1'b0;
            timeout_err <= 1'b1;
            r_state     <= S_SCORE;
          end
        end

        S_SCORE: begin
          shots_left <= shots_left - 4'd1;
          busy       <= 1'b0;
          if (r_resolved)
            last_impact_x <= r_impact;
          if (r_hit) begin
            if (score != 4'd15)
              score <= score + 4'd1;
            target_x <= w_new_tx;
            target_y <= w_new_ty;
          end
          if (shots_left == 4'd1) begin
            game_over <= 1'b1;
            r_state   <= S_OVER;
          end else begin
            r_state   <= S_AIM;
          end
        end

        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shot_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_shot_sequencer
// Brief   : Randomised self-checking bench for shot_sequencer against a
//           transaction-level reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_shot_sequencer;

  localparam int         SHOTS     = 8;
  localparam int         TIMEOUT   = 63;
  localparam logic [9:0] LFSR_SEED = 10'h2A5;

  // Button vector bit positions.
  localparam int B_START = 7, B_FIRE = 6, B_LEFT = 5, B_RIGHT = 4;
  localparam int B_UP = 3, B_DOWN = 2, B_RUN = 1, B_DIR = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] btn = 8'd0;
  logic       result_valid = 1'b0;
  logic       hit = 1'b0;
  logic [4:0] positionx = 5'd0;

  logic [4:0] xpos, rise_out, run_out, target_x, target_y, last_impact_x;
  logic       direction_out, shoot, busy, game_over, timeout_err;
  logic [3:0] score, shots_left;

  shot_sequencer #(
    .SHOTS     (SHOTS),
    .TIMEOUT   (TIMEOUT),
    .LFSR_SEED (LFSR_SEED)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_start     (btn[B_START]),
    .btn_fire      (btn[B_FIRE]),
    .btn_left      (btn[B_LEFT]),
    .btn_right     (btn[B_RIGHT]),
    .btn_up        (btn[B_UP]),
    .btn_down      (btn[B_DOWN]),
    .btn_run       (btn[B_RUN]),
    .btn_dir       (btn[B_DIR]),
    .result_valid  (result_valid),
    .hit           (hit),
    .positionx     (positionx),
    .xpos          (xpos),
    .rise_out      (rise_out),
    .run_out       (run_out),
    .direction_out (direction_out),
    .shoot         (shoot),
    .target_x      (target_x),
    .target_y      (target_y),
    .score         (score),
    .shots_left    (shots_left),
    .last_impact_x (last_impact_x),
    .busy          (busy),
    .game_over     (game_over),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, kept as plain integers.
  int         m_xpos, m_rise, m_run, m_dir, m_tx, m_ty;
  int         m_score, m_shots, m_last, m_terr, m_over, m_hit;
  logic [9:0] m_lfsr, m_lfsr_used;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; remembers the LFSR value the DUT consumed at this edge.
  task automatic tick();
    m_lfsr_used = m_lfsr;
    @(posedge clk);
    m_lfsr = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    #1;
  endtask

  task automatic model_reset();
    m_xpos = 16; m_rise = 0; m_run = 1; m_dir = 0; m_tx = 0; m_ty = 0;
    m_score = 0; m_shots = 0; m_last = 0; m_terr = 0; m_over = 0; m_hit = 0;
  endtask

  task automatic new_target(input logic [9:0] v);
    m_tx = int'(v[4:0]);
    m_ty = (v[9:5] == 5'd0) ? 1 : int'(v[9:5]);
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".xpos"}, 32'(xpos), 32'(m_xpos));
    chk({ph, ".rise"}, 32'(rise_out), 32'(m_rise));
    chk({ph, ".run"}, 32'(run_out), 32'(m_run));
    chk({ph, ".dir"}, 32'(direction_out), 32'(m_dir));
    chk({ph, ".tx"}, 32'(target_x), 32'(m_tx));
    chk({ph, ".ty"}, 32'(target_y), 32'(m_ty));
    chk({ph, ".score"}, 32'(score), 32'(m_score));
    chk({ph, ".shots"}, 32'(shots_left), 32'(m_shots));
    chk({ph, ".last"}, 32'(last_impact_x), 32'(m_last));
    chk({ph, ".terr"}, 32'(timeout_err), 32'(m_terr));
    chk({ph, ".over"}, 32'(game_over), 32'(m_over));
    chk({ph, ".busy"}, 32'(busy), 32'd0);
    chk({ph, ".shoot"}, 32'(shoot), 32'd0);
  endtask

  task automatic start_round();
    btn = 8'd0; btn[B_START] = 1'b1;
    tick();
    btn = 8'd0;
    m_score = 0; m_shots = SHOTS; m_terr = 0; m_over = 0;
    new_target(m_lfsr_used);
    check_all("start");
    tick();
  endtask

  // Press a set of AIM buttons for one cycle; the result must show the next cycle.
  task automatic aim_press(input logic [7:0] m);
    int dx, dr;
    btn = m;
    tick();
    btn = 8'd0;
    dx = (m[B_RIGHT] ? 1 : 0) - (m[B_LEFT] ? 1 : 0);
    dr = (m[B_UP] ? 1 : 0) - (m[B_DOWN] ? 1 : 0);
    m_xpos = m_xpos + dx;
    m_xpos = (m_xpos < 0) ? 0 : (m_xpos > 31) ? 31 : m_xpos;
    m_rise = m_rise + dr;
    m_rise = (m_rise < 0) ? 0 : (m_rise > 31) ? 31 : m_rise;
    if (m[B_RUN]) m_run = (m_run % 31) + 1;
    if (m[B_DIR]) m_dir = 1 - m_dir;
    check_all("aim");
    tick();
  endtask

  // Fire, optionally answer after d WAIT cycles, and check the scored outcome.
  task automatic do_shot(input bit respond, input int d, input bit h, input logic [4:0] px);
    btn = 8'($urandom) & 8'h3F;
    btn[B_FIRE] = 1'b1;
    tick();
    btn = 8'd0;
    chk("fire.shoot_on", 32'(shoot), 32'd1);
    chk("fire.busy", 32'(busy), 32'd1);
    chk("fire.xpos", 32'(xpos), 32'(m_xpos));
    chk("fire.rise", 32'(rise_out), 32'(m_rise));
    tick();
    chk("wait.shoot_off", 32'(shoot), 32'd0);
    chk("wait.busy", 32'(busy), 32'd1);
    if (respond) begin
      for (int i = 0; i < d; i++) begin
        btn = 8'($urandom); hit = 1'($urandom); positionx = 5'($urandom);
        tick();
      end
      btn = 8'd0; result_valid = 1'b1; hit = h; positionx = px;
      tick();
      result_valid = 1'b0; hit = 1'($urandom); positionx = 5'($urandom);
      m_hit = h; m_last = int'(px);
    end else begin
      for (int i = 0; i <= TIMEOUT; i++) begin
        btn = 8'($urandom); hit = 1'($urandom); positionx = 5'($urandom);
        tick();
      end
      btn = 8'd0;
      m_hit = 0; m_terr = 1;
    end
    chk("score_cyc.busy", 32'(busy), 32'd1);
    chk("score_cyc.shots", 32'(shots_left), 32'(m_shots));
    chk("score_cyc.score", 32'(score), 32'(m_score));
    tick();
    m_shots = m_shots - 1;
    if (m_hit != 0) begin
      m_score = (m_score >= 15) ? 15 : m_score + 1;
      new_target(m_lfsr_used);
    end
    m_over = (m_shots == 0) ? 1 : 0;
    check_all("post_shot");
  endtask

  initial begin
    int saved;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    m_lfsr = LFSR_SEED;

    // Round 1: directed items from the plan.
    start_round();
    chk("seed.tx", 32'(target_x), 32'(LFSR_SEED & 10'h1F));
    for (int i = 0; i < 17; i++) aim_press(8'h10);
    chk("xpos_sat", 32'(xpos), 32'd31);
    for (int i = 0; i < 31; i++) aim_press(8'h02);
    chk("run_wrap", 32'(run_out), 32'd1);
    saved = int'(xpos);
    aim_press(8'h30);
    chk("lr_cancel", 32'(xpos), 32'(saved));
    aim_press(8'h20);

    do_shot(1'b1, 3, 1'b1, 5'd9);
    chk("hit.score", 32'(score), 32'd1);
    chk("hit.shots", 32'(shots_left), 32'd7);
    chk("hit.last", 32'(last_impact_x), 32'd9);

    // Stray result in AIM must not be scored.
    result_valid = 1'b1; hit = 1'b1; positionx = 5'd22;
    tick();
    result_valid = 1'b0; hit = 1'b0;
    check_all("stray_rv");
    tick();
    check_all("stray_rv2");

    do_shot(1'b0, 0, 1'b0, 5'd0);
    chk("to.terr", 32'(timeout_err), 32'd1);
    chk("to.score", 32'(score), 32'd1);
    chk("to.shots", 32'(shots_left), 32'd6);

    // Result arriving on the timeout cycle is a real result.
    do_shot(1'b1, TIMEOUT, 1'b1, 5'd17);
    chk("late.last", 32'(last_impact_x), 32'd17);
    chk("late.score", 32'(score), 32'd2);

    while (m_shots > 0)
      do_shot(($urandom_range(0, 3) != 0), $urandom_range(0, 5), 1'($urandom), 5'($urandom));
    chk("over.flag", 32'(game_over), 32'd1);

    btn[B_FIRE] = 1'b1;
    tick();
    btn = 8'd0;
    chk("over.fire_shoot", 32'(shoot), 32'd0);
    chk("over.fire_busy", 32'(busy), 32'd0);
    tick();
    check_all("over.idle");

    // Random rounds.
    for (int r = 0; r < 2; r++) begin
      start_round();
      while (m_shots > 0) begin
        int np;
        np = $urandom_range(0, 4);
        for (int k = 0; k < np; k++) aim_press(8'($urandom) & 8'hBF);
        do_shot(($urandom_range(0, 3) != 0), $urandom_range(0, TIMEOUT),
                1'($urandom), 5'($urandom));
      end
      chk("rnd.over", 32'(game_over), 32'd1);
    end

    // Asynchronous reset in the middle of WAIT.
    start_round();
    aim_press(8'h18);
    btn[B_FIRE] = 1'b1;
    tick();
    btn = 8'd0;
    tick();
    tick();
    chk("midwait.busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    m_lfsr = LFSR_SEED;
    btn[B_FIRE] = 1'b1;
    tick();
    btn = 8'd0;
    chk("idle.fire_shoot", 32'(shoot), 32'd0);
    tick();
    check_all("post_rst_idle");
    start_round();
    do_shot(1'b1, 1, 1'b0, 5'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
